id_skid_reg: RTL and testbench

Parametrised decode-to-execute pipeline register with a valid/ready handshake, and the successor to the fixed-width stall/flush decode register.
- Holds the decoded bundle (PC, ALU operands, store data, packed control) for one stage.
- An optional second (skid) entry decouples execute-stage backpressure from decode timing.
- Inserts a bubble on load hazard and kills contents on flush.
- Keeps saturating stall and bubble statistics counters.

---
 rtl/id_skid_reg.sv | 167 ++++++++++++++++
 tb/tb_id_skid_reg.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_skid_reg
// Purpose  : Decode-to-execute pipeline register with a valid/ready handshake.
//            Holds one decoded bundle (PC, ALU operands, store data, packed
//            control). An optional second skid entry takes execute-stage
//            backpressure off the decode-side ready path. A load hazard holds
//            off acceptance, which becomes a bubble. Flush kills every held
//            entry. Saturating stall and bubble counters are kept.
// Ports    : cpu_clk, cpu_rstn (synchronous, active-low)
//            in_valid/in_ready + in_pc, in_alu_in_0, in_alu_in_1,
//              in_mem_wdata, in_ctrl   decode-side bundle
//            ld_hazard, flush          hazard / kill controls
//            out_valid/out_ready + out_* registered execute-side bundle
//            occupancy                 entries held (0..2)
//            cnt_clr, stall_cnt, bubble_cnt  statistics
// Revision : 1.0  initial release
// ============================================================================
module id_skid_reg #(
    parameter int PC_W    = 30,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 18,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_alu_in_0,
    input  logic [DATA_W-1:0] in_alu_in_1,
    input  logic [DATA_W-1:0] in_mem_wdata,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              ld_hazard,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_alu_in_0,
    output logic [DATA_W-1:0] out_alu_in_1,
    output logic [DATA_W-1:0] out_mem_wdata,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Bundle layout, MSB first: {pc, alu_in_0, alu_in_1, mem_wdata, ctrl}
    localparam int c_BUN_W  = PC_W + 3 * DATA_W + CTRL_W;
    localparam int c_WD_LSB = CTRL_W;
    localparam int c_A1_LSB = CTRL_W + DATA_W;
    localparam int c_A0_LSB = CTRL_W + 2 * DATA_W;
    localparam int c_PC_LSB = CTRL_W + 3 * DATA_W;

    // State value equals the number of held entries, so it drives occupancy
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [c_BUN_W-1:0] r_main;
    logic [c_BUN_W-1:0] r_skid;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic [c_BUN_W-1:0] w_in_bun;
    logic               w_out_valid;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_stall;
    logic               w_bubble;

    assign w_in_bun    = {in_pc, in_alu_in_0, in_alu_in_1, in_mem_wdata, in_ctrl};
    assign w_out_valid = (r_state != c_ST_EMPTY);
    assign w_accept    = in_valid & w_in_ready;
    assign w_stall     = w_out_valid & ~out_ready;
    assign w_bubble    = in_valid & ld_hazard & ~flush;

    // With a skid entry, ready depends only on local state, never on
    // out_ready; without it, ready passes straight through from execute.
    generate
        if (SKID_EN != 0) begin : g_skid_ready
            assign w_in_ready = cpu_rstn & ~ld_hazard & (r_state != c_ST_FULL);
        end else begin : g_pass_ready
            assign w_in_ready = cpu_rstn & ~ld_hazard & (out_ready | ~w_out_valid);
        end
    endgenerate

    // Whenever the main entry goes invalid its control field is zeroed, so
    // out_ctrl (and with it gpr_wen / mem_op) reads zero on any bubble.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            r_state <= c_ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state               <= c_ST_EMPTY;
            r_main[CTRL_W-1:0]    <= '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= w_in_bun;
                        r_state <= c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (out_ready) begin
                        if (w_accept) begin
                            r_main <= w_in_bun;
                        end else begin
                            r_state            <= c_ST_EMPTY;
                            r_main[CTRL_W-1:0] <= '0;
                        end
                    end else if (w_accept && (SKID_EN != 0)) begin
                        // Main is stalled: park the newcomer behind it
                        r_skid  <= w_in_bun;
                        r_state <= c_ST_FULL;
                    end
                end
                c_ST_FULL: begin
                    if (out_ready) begin
                        r_main  <= r_skid;
                        r_state <= c_ST_ONE;
                    end
                end
                default: begin
                    r_state            <= c_ST_EMPTY;
                    r_main[CTRL_W-1:0] <= '0;
                end
            endcase
        end
    end

    // Statistics: clear beats increment, and both counters stick at max.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn || cnt_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign out_pc        = r_main[c_PC_LSB +: PC_W];
    assign out_alu_in_0  = r_main[c_A0_LSB +: DATA_W];
    assign out_alu_in_1  = r_main[c_A1_LSB +: DATA_W];
    assign out_mem_wdata = r_main[c_WD_LSB +: DATA_W];
    assign out_ctrl      = r_main[CTRL_W-1:0];
    assign occupancy     = r_state;
    assign stall_cnt     = r_stall_cnt;
    assign bubble_cnt    = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_skid_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_id_skid_reg
// Purpose  : Self-checking bench for id_skid_reg. Three instances:
//            dut_a (skid, 16-bit counters) and dut_c (skid, 4-bit counters)
//            share input set 0; dut_b (no skid) uses input set 1. Expected
//            values come from a capacity-limited FIFO model of each stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_skid_reg;

    typedef logic [143:0] bun_t;   // {pc[29:0], a0, a1, wdata, ctrl[17:0]}

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] iv   = '0;
    logic [1:0] ldh  = '0;
    logic [1:0] fl   = '0;
    logic [1:0] ordy = '1;
    logic [1:0] clr  = '0;
    bun_t       din [2];

    logic [2:0]  rdy, val;
    bun_t        bun_a, bun_b, bun_c;
    logic [1:0]  occ_a, occ_b, occ_c;
    logic [15:0] st_a, st_b, bb_a, bb_b;
    logic [3:0]  st_c, bb_c;

    id_skid_reg #(.SKID_EN(1), .CNT_W(16)) dut_a (
        .cpu_clk(clk), .cpu_rstn(rstn), .in_valid(iv[0]), .in_ready(rdy[0]),
        .in_pc(din[0][143:114]), .in_alu_in_0(din[0][113:82]), .in_alu_in_1(din[0][81:50]),
        .in_mem_wdata(din[0][49:18]), .in_ctrl(din[0][17:0]), .ld_hazard(ldh[0]), .flush(fl[0]),
        .out_valid(val[0]), .out_ready(ordy[0]), .out_pc(bun_a[143:114]),
        .out_alu_in_0(bun_a[113:82]), .out_alu_in_1(bun_a[81:50]), .out_mem_wdata(bun_a[49:18]),
        .out_ctrl(bun_a[17:0]), .occupancy(occ_a), .cnt_clr(clr[0]), .stall_cnt(st_a), .bubble_cnt(bb_a));

    id_skid_reg #(.SKID_EN(0), .CNT_W(16)) dut_b (
        .cpu_clk(clk), .cpu_rstn(rstn), .in_valid(iv[1]), .in_ready(rdy[1]),
        .in_pc(din[1][143:114]), .in_alu_in_0(din[1][113:82]), .in_alu_in_1(din[1][81:50]),
        .in_mem_wdata(din[1][49:18]), .in_ctrl(din[1][17:0]), .ld_hazard(ldh[1]), .flush(fl[1]),
        .out_valid(val[1]), .out_ready(ordy[1]), .out_pc(bun_b[143:114]),
        .out_alu_in_0(bun_b[113:82]), .out_alu_in_1(bun_b[81:50]), .out_mem_wdata(bun_b[49:18]),
        .out_ctrl(bun_b[17:0]), .occupancy(occ_b), .cnt_clr(clr[1]), .stall_cnt(st_b), .bubble_cnt(bb_b));

    id_skid_reg #(.SKID_EN(1), .CNT_W(4)) dut_c (
        .cpu_clk(clk), .cpu_rstn(rstn), .in_valid(iv[0]), .in_ready(rdy[2]),
        .in_pc(din[0][143:114]), .in_alu_in_0(din[0][113:82]), .in_alu_in_1(din[0][81:50]),
        .in_mem_wdata(din[0][49:18]), .in_ctrl(din[0][17:0]), .ld_hazard(ldh[0]), .flush(fl[0]),
        .out_valid(val[2]), .out_ready(ordy[0]), .out_pc(bun_c[143:114]),
        .out_alu_in_0(bun_c[113:82]), .out_alu_in_1(bun_c[81:50]), .out_mem_wdata(bun_c[49:18]),
        .out_ctrl(bun_c[17:0]), .occupancy(occ_c), .cnt_clr(clr[0]), .stall_cnt(st_c), .bubble_cnt(bb_c));

    int checks   = 0;
    int failures = 0;

    // Reference model: per input set, a FIFO of capacity 2 (skid) or 1.
    bun_t m_ent [2][2];
    int   m_n   [2];
    int   m_st  [3];
    int   m_bb  [3];

    function automatic bun_t rnd_bun(int pc);
        logic [31:0] p;
        p = pc;
        return {p[29:0], $urandom, $urandom, $urandom, 18'($urandom)};
    endfunction

    function automatic bit exp_ready(int k);
        if (!rstn || ldh[k]) return 1'b0;
        if (k == 0) return (m_n[0] < 2);
        return (m_n[1] == 0) || ordy[1];
    endfunction

    task automatic chk(string tag, int j, bun_t obs, bun_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, j, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 3; j++) begin
            int          s;
            logic [1:0]  oc;
            bun_t        b;
            logic [15:0] st, bb;
            bun_t        ectl;
            s = (j == 1) ? 1 : 0;
            case (j)
                0:       begin oc = occ_a; b = bun_a; st = st_a; bb = bb_a; end
                1:       begin oc = occ_b; b = bun_b; st = st_b; bb = bb_b; end
                default: begin oc = occ_c; b = bun_c; st = 16'(st_c); bb = 16'(bb_c); end
            endcase
            ectl = (m_n[s] > 0) ? bun_t'(m_ent[s][0][17:0]) : bun_t'(0);
            chk("in_ready",   j, bun_t'(rdy[j]), bun_t'(exp_ready(s)));
            chk("out_valid",  j, bun_t'(val[j]), bun_t'(m_n[s] > 0));
            chk("occupancy",  j, bun_t'(oc),     bun_t'(m_n[s]));
            chk("out_ctrl",   j, bun_t'(b[17:0]), ectl);
            if (m_n[s] > 0) chk("bundle", j, b, m_ent[s][0]);
            chk("stall_cnt",  j, bun_t'(st), bun_t'(m_st[j]));
            chk("bubble_cnt", j, bun_t'(bb), bun_t'(m_bb[j]));
        end
    endtask

    task automatic model_update();
        bit acc [2];
        bit est [2];
        bit ebb [2];
        for (int k = 0; k < 2; k++) begin
            acc[k] = iv[k] && exp_ready(k);
            est[k] = (m_n[k] > 0) && !ordy[k];
            ebb[k] = iv[k] && ldh[k] && !fl[k];
        end
        for (int j = 0; j < 3; j++) begin
            int s, mx;
            s  = (j == 1) ? 1 : 0;
            mx = (j == 2) ? 15 : 65535;
            if (!rstn || clr[s]) begin
                m_st[j] = 0;
                m_bb[j] = 0;
            end else begin
                if (est[s] && m_st[j] < mx) m_st[j]++;
                if (ebb[s] && m_bb[j] < mx) m_bb[j]++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (!rstn || fl[k]) begin
                m_n[k] = 0;
            end else begin
                if (m_n[k] > 0 && ordy[k]) begin
                    m_ent[k][0] = m_ent[k][1];
                    m_n[k]--;
                end
                if (acc[k]) begin
                    m_ent[k][m_n[k]] = din[k];
                    m_n[k]++;
                end
            end
        end
    endtask

    task automatic pre();
        #1;
        check_all();
    endtask

    task automatic post();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        pre();
        post();
    endtask

    task automatic idle();
        iv = '0; ldh = '0; fl = '0; ordy = '1; clr = '0;
    endtask

    // Send PCs base..base+2 on set k, execute side stalled for `hold` cycles.
    task automatic stream(int k, int base, int hold);
        int idx, cyc, maxocc, j;
        int got [$];
        idx = 0; cyc = 0; maxocc = 0;
        j = (k == 0) ? 0 : 1;
        din[k] = rnd_bun(base);
        while ((idx < 3 || m_n[k] > 0) && cyc < 40) begin
            bit   a;
            bun_t ob;
            logic [1:0] oc;
            ordy[k] = (cyc >= hold);
            iv[k]   = (idx < 3);
            pre();
            ob = (k == 0) ? bun_a : bun_b;
            oc = (k == 0) ? occ_a : occ_b;
            if (cyc == hold - 1) begin
                chk("stall_occ",   j, bun_t'(oc), bun_t'((k == 0) ? 2 : 1));
                chk("stall_ready", j, bun_t'(rdy[j]), bun_t'(0));
            end
            if (val[j] && ordy[k]) got.push_back(int'(ob[143:114]));
            if (int'(oc) > maxocc) maxocc = int'(oc);
            a = iv[k] && exp_ready(k);
            post();
            if (a) begin
                idx++;
                din[k] = rnd_bun(base + idx);
            end
            cyc++;
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        chk("order_len", j, bun_t'(got.size()), bun_t'(3));
        for (int i = 0; i < got.size(); i++) chk("order_pc", j, bun_t'(got[i]), bun_t'(base + i));
        chk("max_occ", j, bun_t'(maxocc), bun_t'((k == 0) ? 2 : 1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        din[0] = '0;
        din[1] = '0;
        for (int k = 0; k < 2; k++) m_n[k] = 0;
        for (int j = 0; j < 3; j++) begin m_st[j] = 0; m_bb[j] = 0; end
        repeat (3) @(posedge clk);
        #1;
        cycle();                       // still in reset: in_ready low
        rstn = 1'b1;
        #1;
        chk("reset_bundle", 0, bun_a, bun_t'(0));
        chk("reset_bundle", 1, bun_b, bun_t'(0));
        chk("reset_bundle", 2, bun_c, bun_t'(0));
        chk("reset_ready",  0, bun_t'(rdy[0]), bun_t'(1));
        cycle();

        // Reset while both entries are held
        ordy[0] = 1'b0; iv[0] = 1'b1;
        din[0] = rnd_bun('h50); cycle();
        din[0] = rnd_bun('h51); cycle();
        iv[0] = 1'b0;
        chk("fill_occ", 0, bun_t'(occ_a), bun_t'(2));
        rstn = 1'b0; cycle();
        rstn = 1'b1; ordy[0] = 1'b1;
        #1;
        chk("rst_valid", 0, bun_t'(val[0]), bun_t'(0));
        chk("rst_occ",   0, bun_t'(occ_a), bun_t'(0));
        chk("rst_ready", 0, bun_t'(rdy[0]), bun_t'(1));
        chk("rst_stall", 0, bun_t'(st_a), bun_t'(0));
        chk("rst_bub",   0, bun_t'(bb_a), bun_t'(0));
        cycle();

        // Backpressure into the skid entry, then ordered drain
        clr = '1; cycle(); clr = '0;
        stream(0, 'h100, 5);
        chk("skid_stall_cnt", 0, bun_t'(st_a), bun_t'(4));

        // Load hazard: two bubbles, then acceptance
        clr = '1; cycle(); clr = '0;
        ordy[0] = 1'b1; iv[0] = 1'b1; ldh[0] = 1'b1;
        din[0] = rnd_bun('h200) | bun_t'(18'h3ffff);
        cycle(); cycle();
        chk("haz_valid", 0, bun_t'(val[0]), bun_t'(0));
        chk("haz_ctrl",  0, bun_t'(bun_a[17:0]), bun_t'(0));
        chk("haz_bub",   0, bun_t'(bb_a), bun_t'(2));
        ldh[0] = 1'b0; cycle();
        iv[0] = 1'b0;
        #1;
        chk("haz_accept", 0, bun_t'(val[0]), bun_t'(1));
        chk("haz_pc",     0, bun_t'(bun_a[143:114]), bun_t'('h200));
        cycle();

        // Flush while full with a simultaneous valid input
        ordy[0] = 1'b0; iv[0] = 1'b1;
        din[0] = rnd_bun('h300); cycle();
        din[0] = rnd_bun('h301); cycle();
        fl[0] = 1'b1; din[0] = rnd_bun('h333); cycle();
        fl[0] = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b1;
        #1;
        chk("flush_valid", 0, bun_t'(val[0]), bun_t'(0));
        chk("flush_occ",   0, bun_t'(occ_a), bun_t'(0));
        chk("flush_ctrl",  0, bun_t'(bun_a[17:0]), bun_t'(0));
        cycle();
        chk("flush_discard", 0, bun_t'(val[0]), bun_t'(0));
        cycle();

        // Single-register build: pass-through ready, occupancy capped at 1
        stream(1, 'h100, 5);

        // Counter saturation on the 4-bit instance, then clear during stall
        clr = '1; iv[0] = 1'b1; ordy[0] = 1'b0; din[0] = rnd_bun('h400);
        cycle();
        clr = '0; iv[0] = 1'b0;
        repeat (20) cycle();
        chk("sat_stall4",  2, bun_t'(st_c), bun_t'(15));
        chk("sat_stall16", 0, bun_t'(st_a), bun_t'(20));
        clr = '1; cycle(); clr = '0;
        chk("clr_stall4",  2, bun_t'(st_c), bun_t'(0));
        chk("clr_stall16", 0, bun_t'(st_a), bun_t'(0));
        ordy[0] = 1'b1; cycle();

        // Randomised traffic on both input sets
        for (int n = 0; n < 400; n++) begin
            rstn = ($urandom_range(99) != 0);
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(9) < 7);
                ldh[k]  = ($urandom_range(9) < 2);
                fl[k]   = ($urandom_range(19) == 0);
                ordy[k] = ($urandom_range(9) < 6);
                clr[k]  = ($urandom_range(49) == 0);
                din[k]  = rnd_bun(int'($urandom));
            end
            cycle();
        end
        idle();
        rstn = 1'b1;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
